api_reg_initiator: RTL and testbench
====================================

// Module: api_reg_initiator
// PURPOSE
//  Master side of the API register protocol: issues single CMD_WR/CMD_RD transactions to a register on any
//  slot/FPGA and returns read data (or a timeout) to local logic. One transaction is outstanding at a time.
//  Sits between user logic and the SciEngines API output/input register FIFOs.
//  Mirrors the responder slave, which answers CMD_RD by writing back to the requester's src_reg.
// PARAMETERS
//  RSP_REG         8'hF0  local register address placed in src_reg; read responses must target it
//  TIMEOUT_CYCLES  1024   cycles to wait in WAIT_RSP before reporting timeout (>=2)
//  DROP_W          16     width of the saturating dropped-word counter
// PORTS
//  api_clk_in          in   1                    clock
//  reset               in   1                    asynchronous, active-high
//  req_valid           in   1                    local request present
//  req_ready           out  1                    high in IDLE only; accepted when req_valid&req_ready
//  req_rd              in   1                    1=read, 0=write
//  req_slot            in   C_LENGTH_ADDR_SLOT   target slot
//  req_fpga            in   C_LENGTH_ADDR_FPGA   target FPGA
//  req_reg             in   C_LENGTH_ADDR_REG    target register
//  req_data            in   C_LENGTH_DATA        write data (ignored for reads)
//  rsp_valid           out  1                    1-cycle completion pulse
//  rsp_timeout         out  1                    qualifies rsp_valid: read timed out
//  rsp_data            out  C_LENGTH_DATA        read data; 0 for writes/timeouts
//  busy                out  1                    state != IDLE
//  drop_cnt            out  DROP_W               unmatched input words discarded
//  api_o_clk_out       out  1                    = api_clk_in
//  api_o_rfd_in        in   1                    output FIFO ready for data
//  api_o_tgt_slot_out  out  C_LENGTH_ADDR_SLOT   latched req_slot
//  api_o_tgt_fpga_out  out  C_LENGTH_ADDR_FPGA   latched req_fpga
//  api_o_tgt_reg_out   out  C_LENGTH_ADDR_REG    latched req_reg
//  api_o_tgt_cmd_out   out  C_LENGTH_CMD         CMD_RD or CMD_WR
//  api_o_src_reg_out   out  C_LENGTH_ADDR_REG    RSP_REG
//  api_o_src_cmd_out   out  C_LENGTH_CMD         CMD_WR
//  api_o_data_out      out  C_LENGTH_DATA        latched req_data (0 for reads)
//  api_o_wr_en_out     out  1                    1-cycle push pulse
//  api_i_clk_out       out  1                    = api_clk_in
//  api_i_src_slot_in / api_i_src_fpga_in  in  SLOT/FPGA width  response origin
//  api_i_tgt_reg_in    in   C_LENGTH_ADDR_REG    response target register
//  api_i_tgt_cmd_in    in   C_LENGTH_CMD         response command
//  api_i_data_in       in   C_LENGTH_DATA        response data
//  api_i_empty_in      in   1                    input FIFO empty (FWFT: head valid when 0)
//  api_i_rd_en_out     out  1                    1-cycle pop pulse
// BEHAVIOUR
//  Reset: state=IDLE, all outputs/latches 0 except req_ready=1; drop_cnt=0; timeout counter=0.
//  IDLE: on req_valid, latch req_* and go to SEND next cycle (req_ready low from that cycle on).
//  SEND: hold api_o_* stable; when api_o_rfd_in=1, assert api_o_wr_en_out for exactly one cycle, then:
//    write -> DONE (rsp_valid, rsp_timeout=0, rsp_data=0); read -> WAIT_RSP with counter cleared.
//  WAIT_RSP: counter increments each cycle; head word matches if tgt_cmd==CMD_WR, tgt_reg==RSP_REG,
//    src_slot/src_fpga == latched target. Match -> pop, rsp_data=api_i_data_in, -> DONE.
//    Counter reaches TIMEOUT_CYCLES-1 without match -> DONE with rsp_timeout=1, rsp_data=0.
//    Match and timeout in the same cycle: match wins.
//  DONE: rsp_valid high one cycle, then IDLE. Latency: write = 1 cycle after wr_en pulse.
//  Input pop rule (all states): at most one pop every two cycles (no rd_en in the cycle after a pop,
//    allowing the empty flag to update). Non-matching words, and words arriving outside WAIT_RSP, are
//    popped and discarded; drop_cnt += 1, saturating at all-ones.
//  Reset mid-transaction: abort immediately; no wr_en or rsp_valid is issued afterwards.
// TESTING
//  Write slot=1,fpga=2,reg=3,data=64'hDEAD_BEEF_0000_0001, rfd=1 -> one wr_en, tgt_cmd=CMD_WR, rsp_valid 1 cycle later.
//  rfd=0 for 5 cycles during SEND -> wr_en only after rfd rises, outputs stable throughout.
//  Read reg=7; response tgt_reg=RSP_REG, data=64'h1234 after 10 cycles -> rsp_data=64'h1234, timeout=0, one pop.
//  Read with no response, TIMEOUT_CYCLES=16 -> rsp_valid+rsp_timeout exactly 16 cycles after WAIT_RSP entry.
//  Stray word (tgt_reg!=RSP_REG) ahead of valid response -> drop_cnt=1, pops 2 cycles apart, correct rsp_data.
//  Assert reset during WAIT_RSP -> busy=0, req_ready=1, no rsp_valid; late response later -> drop_cnt=1.

Source files
------------

// File: rtl/api_reg_initiator.sv
// api_reg_initiator
//   Master side of the API register protocol. Accepts one local read/write
//   request at a time, pushes a single command word into the API output FIFO,
//   and for reads waits for the responder to write the value back to RSP_REG.
//   The local side gets one rsp_valid pulse per request, flagged with
//   rsp_timeout when a read is never answered.
//
// Ports
//   api_clk_in, reset             clock, asynchronous active-high reset
//   req_valid/req_ready/req_*     local request handshake and payload
//   rsp_valid/rsp_timeout/rsp_data  one-cycle completion report
//   busy                          transaction in progress
//   drop_cnt                      saturating count of discarded input words
//   api_o_*                       API output register FIFO (command push)
//   api_i_*                       API input register FIFO (FWFT, response pop)
//
// States
//   IDLE     | req_ready high, waiting for a local request
//   SEND     | command latched on api_o_*, waiting for rfd to push it
//   PUSHED   | write pushed (wr_en high this cycle), completion follows
//   WAIT_RSP | read pushed, scanning input FIFO for the matching write-back
//   DONE     | rsp_valid high for this single cycle

module api_reg_initiator #(
  parameter int C_LENGTH_ADDR_SLOT = 4,
  parameter int C_LENGTH_ADDR_FPGA = 4,
  parameter int C_LENGTH_ADDR_REG  = 8,
  parameter int C_LENGTH_CMD       = 4,
  parameter int C_LENGTH_DATA      = 64,
  parameter logic [C_LENGTH_CMD-1:0]      CMD_WR = 4'h1,
  parameter logic [C_LENGTH_CMD-1:0]      CMD_RD = 4'h2,
  parameter logic [C_LENGTH_ADDR_REG-1:0] RSP_REG = 8'hF0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DROP_W         = 16
) (
  input  logic                          api_clk_in,
  input  logic                          reset,

  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rd,
  input  logic [C_LENGTH_ADDR_SLOT-1:0] req_slot,
  input  logic [C_LENGTH_ADDR_FPGA-1:0] req_fpga,
  input  logic [C_LENGTH_ADDR_REG-1:0]  req_reg,
  input  logic [C_LENGTH_DATA-1:0]      req_data,

  output logic                          rsp_valid,
  output logic                          rsp_timeout,
  output logic [C_LENGTH_DATA-1:0]      rsp_data,
  output logic                          busy,
  output logic [DROP_W-1:0]             drop_cnt,

  output logic                          api_o_clk_out,
  input  logic                          api_o_rfd_in,
  output logic [C_LENGTH_ADDR_SLOT-1:0] api_o_tgt_slot_out,
  output logic [C_LENGTH_ADDR_FPGA-1:0] api_o_tgt_fpga_out,
  output logic [C_LENGTH_ADDR_REG-1:0]  api_o_tgt_reg_out,
  output logic [C_LENGTH_CMD-1:0]       api_o_tgt_cmd_out,
  output logic [C_LENGTH_ADDR_REG-1:0]  api_o_src_reg_out,
  output logic [C_LENGTH_CMD-1:0]       api_o_src_cmd_out,
  output logic [C_LENGTH_DATA-1:0]      api_o_data_out,
  output logic                          api_o_wr_en_out,

  output logic                          api_i_clk_out,
  input  logic [C_LENGTH_ADDR_SLOT-1:0] api_i_src_slot_in,
  input  logic [C_LENGTH_ADDR_FPGA-1:0] api_i_src_fpga_in,
  input  logic [C_LENGTH_ADDR_REG-1:0]  api_i_tgt_reg_in,
  input  logic [C_LENGTH_CMD-1:0]       api_i_tgt_cmd_in,
  input  logic [C_LENGTH_DATA-1:0]      api_i_data_in,
  input  logic                          api_i_empty_in,
  output logic                          api_i_rd_en_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    PUSHED   = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state;
  logic             rd_lat;
  logic [CNT_W-1:0] tmo_cnt;

  logic pop_ok;
  logic head_match;
  logic take;

  assign api_o_clk_out = api_clk_in;
  assign api_i_clk_out = api_clk_in;

  // A pop is only allowed when the pop pulse is not already high: the head
  // shown during the pop cycle is the word being removed, and the FIFO needs
  // that cycle to present the next word and update empty.
  assign pop_ok = !api_i_empty_in && !api_i_rd_en_out;

  assign head_match = (api_i_tgt_cmd_in  == CMD_WR) &&
                      (api_i_tgt_reg_in  == RSP_REG) &&
                      (api_i_src_slot_in == api_o_tgt_slot_out) &&
                      (api_i_src_fpga_in == api_o_tgt_fpga_out);

  assign take = (state == WAIT_RSP) && pop_ok && head_match;

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rd_lat             <= 1'b0;
      tmo_cnt            <= '0;
      req_ready          <= 1'b1;
      busy               <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_timeout        <= 1'b0;
      rsp_data           <= '0;
      drop_cnt           <= '0;
      api_o_tgt_slot_out <= '0;
      api_o_tgt_fpga_out <= '0;
      api_o_tgt_reg_out  <= '0;
      api_o_tgt_cmd_out  <= '0;
      api_o_src_reg_out  <= '0;
      api_o_src_cmd_out  <= '0;
      api_o_data_out     <= '0;
      api_o_wr_en_out    <= 1'b0;
      api_i_rd_en_out    <= 1'b0;
    end else begin
      api_o_wr_en_out <= 1'b0;
      api_i_rd_en_out <= 1'b0;
      rsp_valid       <= 1'b0;

      // Every available input word is consumed; anything that is not the
      // awaited read response is discarded and counted.
      if (pop_ok) begin
        api_i_rd_en_out <= 1'b1;
        if (!take && (drop_cnt != {DROP_W{1'b1}})) begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            api_o_tgt_slot_out <= req_slot;
            api_o_tgt_fpga_out <= req_fpga;
            api_o_tgt_reg_out  <= req_reg;
            api_o_tgt_cmd_out  <= req_rd ? CMD_RD : CMD_WR;
            api_o_src_reg_out  <= RSP_REG;
            api_o_src_cmd_out  <= CMD_WR;
            api_o_data_out     <= req_rd ? '0 : req_data;
            rd_lat             <= req_rd;
            req_ready          <= 1'b0;
            busy               <= 1'b1;
            state              <= SEND;
          end
        end

        SEND: begin
          if (api_o_rfd_in) begin
            api_o_wr_en_out <= 1'b1;
            if (rd_lat) begin
              tmo_cnt <= '0;
              state   <= WAIT_RSP;
            end else begin
              state   <= PUSHED;
            end
          end
        end

        PUSHED: begin
          rsp_valid   <= 1'b1;
          rsp_timeout <= 1'b0;
          rsp_data    <= '0;
          state       <= DONE;
        end

        WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          // A response arriving on the last counted cycle still completes
          // the read normally.
          if (take) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_data    <= api_i_data_in;
            state       <= DONE;
          end else if (tmo_cnt == CNT_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            state       <= DONE;
          end
        end

        DONE: begin
          rsp_timeout <= 1'b0;
          rsp_data    <= '0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_api_reg_initiator.sv
module tb_api_reg_initiator;

  localparam int SW = 4;
  localparam int FW = 4;
  localparam int RW = 8;
  localparam int CW = 4;
  localparam int DW = 64;
  localparam int DROPW = 16;
  localparam logic [CW-1:0] CMD_WR = 4'h1;
  localparam logic [CW-1:0] CMD_RD = 4'h2;
  localparam logic [RW-1:0] RSP_REG = 8'hF0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rd = 1'b0;
  logic [SW-1:0] req_slot = '0;
  logic [FW-1:0] req_fpga = '0;
  logic [RW-1:0] req_reg = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [DROPW-1:0] drop_cnt;
  logic          o_clk;
  logic          rfd = 1'b1;
  logic [SW-1:0] o_slot;
  logic [FW-1:0] o_fpga;
  logic [RW-1:0] o_reg;
  logic [CW-1:0] o_cmd;
  logic [RW-1:0] o_src_reg;
  logic [CW-1:0] o_src_cmd;
  logic [DW-1:0] o_data;
  logic          wr_en;
  logic          i_clk;
  logic [SW-1:0] i_slot = '0;
  logic [FW-1:0] i_fpga = '0;
  logic [RW-1:0] i_reg = '0;
  logic [CW-1:0] i_cmd = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_empty = 1'b1;
  logic          rd_en;

  api_reg_initiator #(
    .C_LENGTH_ADDR_SLOT(SW), .C_LENGTH_ADDR_FPGA(FW), .C_LENGTH_ADDR_REG(RW),
    .C_LENGTH_CMD(CW), .C_LENGTH_DATA(DW), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD),
    .RSP_REG(RSP_REG), .TIMEOUT_CYCLES(16), .DROP_W(DROPW)
  ) dut (
    .api_clk_in(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_slot(req_slot), .req_fpga(req_fpga), .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_data(rsp_data),
    .busy(busy), .drop_cnt(drop_cnt),
    .api_o_clk_out(o_clk), .api_o_rfd_in(rfd),
    .api_o_tgt_slot_out(o_slot), .api_o_tgt_fpga_out(o_fpga), .api_o_tgt_reg_out(o_reg),
    .api_o_tgt_cmd_out(o_cmd), .api_o_src_reg_out(o_src_reg), .api_o_src_cmd_out(o_src_cmd),
    .api_o_data_out(o_data), .api_o_wr_en_out(wr_en),
    .api_i_clk_out(i_clk),
    .api_i_src_slot_in(i_slot), .api_i_src_fpga_in(i_fpga), .api_i_tgt_reg_in(i_reg),
    .api_i_tgt_cmd_in(i_cmd), .api_i_data_in(i_data), .api_i_empty_in(i_empty),
    .api_i_rd_en_out(rd_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [FW-1:0] fpga;
    logic [RW-1:0] rg;
    logic [CW-1:0] cmd;
    logic [DW-1:0] data;
  } word_t;

  word_t fifo_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cnt = 0, wr_cyc = 0;
  int rsp_cnt = 0, rsp_cyc = 0;
  int pop_cnt = 0, pop_cyc = 0, prev_pop_cyc = 0;
  logic          rsp_to_s;
  logic [DW-1:0] rsp_dat_s;
  logic [SW-1:0] s_slot;
  logic [FW-1:0] s_fpga;
  logic [RW-1:0] s_reg, s_src_reg;
  logic [CW-1:0] s_cmd, s_src_cmd;
  logic [DW-1:0] s_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Input FIFO model (FWFT) and output monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++; wr_cyc = cyc;
      s_slot = o_slot; s_fpga = o_fpga; s_reg = o_reg; s_cmd = o_cmd;
      s_src_reg = o_src_reg; s_src_cmd = o_src_cmd; s_data = o_data;
    end
    if (rsp_valid) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_to_s = rsp_timeout; rsp_dat_s = rsp_data;
    end
    if (rd_en) begin
      pop_cnt++; prev_pop_cyc = pop_cyc; pop_cyc = cyc;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    i_empty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) begin
      i_slot = fifo_q[0].slot; i_fpga = fifo_q[0].fpga; i_reg = fifo_q[0].rg;
      i_cmd = fifo_q[0].cmd; i_data = fifo_q[0].data;
    end
  end

  task automatic push_word(input logic [SW-1:0] s, input logic [FW-1:0] f,
                           input logic [RW-1:0] r, input logic [CW-1:0] c,
                           input logic [DW-1:0] d);
    word_t w;
    w.slot = s; w.fpga = f; w.rg = r; w.cmd = c; w.data = d;
    @(negedge clk); #1;
    fifo_q.push_back(w);
    i_empty = 1'b0;
    i_slot = fifo_q[0].slot; i_fpga = fifo_q[0].fpga; i_reg = fifo_q[0].rg;
    i_cmd = fifo_q[0].cmd; i_data = fifo_q[0].data;
  endtask

  task automatic issue(input logic rd, input logic [SW-1:0] s, input logic [FW-1:0] f,
                       input logic [RW-1:0] r, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_rd = rd; req_slot = s; req_fpga = f; req_reg = r; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev);
    for (int i = 0; i < 200 && rsp_cnt == prev; i++) @(negedge clk);
    tests++;
    if (rsp_cnt == prev) begin
      fails++;
      $display("FAIL wait_rsp: no rsp_valid within 200 cycles, got %0d pulses, required %0d", rsp_cnt - prev, 1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_hs: req_ready=%b busy=%b, required 1 0", req_ready, busy);
    end
    tests++;
    if (rsp_valid !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0 || drop_cnt !== '0) begin
      fails++; $display("FAIL reset_out: rsp_valid=%b wr_en=%b rd_en=%b drop=%0d, required 0 0 0 0",
                        rsp_valid, wr_en, rd_en, drop_cnt);
    end
    tests++;
    if (o_cmd !== '0 || o_data !== '0 || o_src_reg !== '0 || rsp_data !== '0) begin
      fails++; $display("FAIL reset_lat: cmd=%h data=%h src_reg=%h rsp_data=%h, required all 0",
                        o_cmd, o_data, o_src_reg, rsp_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int w0, r0;
    rfd = 1'b1; w0 = wr_cnt; r0 = rsp_cnt;
    issue(1'b0, 4'd1, 4'd2, 8'd3, 64'hDEAD_BEEF_0000_0001);
    tests++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL write_busy: req_ready=%b busy=%b, required 0 1", req_ready, busy);
    end
    wait_rsp(r0);
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 1 || rsp_cnt - r0 !== 1) begin
      fails++; $display("FAIL write_pulses: wr_en=%0d rsp_valid=%0d, required 1 1", wr_cnt - w0, rsp_cnt - r0);
    end
    tests++;
    if (rsp_cyc - wr_cyc !== 1) begin
      fails++; $display("FAIL write_latency: got %0d cycles, required 1", rsp_cyc - wr_cyc);
    end
    tests++;
    if (s_slot !== 4'd1 || s_fpga !== 4'd2 || s_reg !== 8'd3 || s_cmd !== CMD_WR ||
        s_data !== 64'hDEAD_BEEF_0000_0001 || s_src_reg !== RSP_REG || s_src_cmd !== CMD_WR) begin
      fails++; $display("FAIL write_fields: slot=%h fpga=%h reg=%h cmd=%h data=%h src=%h/%h, required 1 2 03 1 deadbeef00000001 f0/1",
                        s_slot, s_fpga, s_reg, s_cmd, s_data, s_src_reg, s_src_cmd);
    end
    tests++;
    if (rsp_to_s !== 1'b0 || rsp_dat_s !== '0) begin
      fails++; $display("FAIL write_rsp: timeout=%b data=%h, required 0 0", rsp_to_s, rsp_dat_s);
    end
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL write_idle: req_ready=%b busy=%b, required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_rfd_stall();
    int w0, r0, stall_end;
    bit bad;
    bad = 0;
    rfd = 1'b0; w0 = wr_cnt; r0 = rsp_cnt;
    issue(1'b0, 4'd4, 4'd5, 8'h09, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 5; i++) begin
      if (wr_en !== 1'b0 || o_slot !== 4'd4 || o_fpga !== 4'd5 || o_reg !== 8'h09 ||
          o_cmd !== CMD_WR || o_data !== 64'h0123_4567_89AB_CDEF) bad = 1;
      @(negedge clk);
    end
    stall_end = cyc;
    tests++;
    if (bad || wr_cnt != w0) begin
      fails++; $display("FAIL rfd_stall: outputs moved or %0d pushes during stall, required stable and 0", wr_cnt - w0);
    end
    rfd = 1'b1;
    wait_rsp(r0);
    repeat (2) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 1 || wr_cyc <= stall_end) begin
      fails++; $display("FAIL rfd_push: %0d pushes at cycle %0d, required 1 after cycle %0d", wr_cnt - w0, wr_cyc, stall_end);
    end
  endtask

  task automatic test_read();
    int p0, r0;
    logic [DROPW-1:0] d0;
    p0 = pop_cnt; r0 = rsp_cnt; d0 = drop_cnt;
    issue(1'b1, 4'd1, 4'd2, 8'h07, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (10) @(negedge clk);
    push_word(4'd1, 4'd2, RSP_REG, CMD_WR, 64'h1234);
    wait_rsp(r0);
    repeat (3) @(negedge clk);
    tests++;
    if (s_cmd !== CMD_RD || s_reg !== 8'h07 || s_data !== '0 || s_src_reg !== RSP_REG) begin
      fails++; $display("FAIL read_cmd: cmd=%h reg=%h data=%h src=%h, required 2 07 0 f0", s_cmd, s_reg, s_data, s_src_reg);
    end
    tests++;
    if (rsp_dat_s !== 64'h1234 || rsp_to_s !== 1'b0) begin
      fails++; $display("FAIL read_rsp: data=%h timeout=%b, required 1234 0", rsp_dat_s, rsp_to_s);
    end
    tests++;
    if (pop_cnt - p0 !== 1 || drop_cnt !== d0) begin
      fails++; $display("FAIL read_pop: pops=%0d drop=%0d, required 1 %0d", pop_cnt - p0, drop_cnt, d0);
    end
  endtask

  task automatic test_timeout();
    int r0;
    r0 = rsp_cnt;
    issue(1'b1, 4'd3, 4'd3, 8'h22, '0);
    wait_rsp(r0);
    repeat (2) @(negedge clk);
    tests++;
    if (rsp_cyc - wr_cyc !== 16) begin
      fails++; $display("FAIL timeout_lat: got %0d cycles, required 16", rsp_cyc - wr_cyc);
    end
    tests++;
    if (rsp_to_s !== 1'b1 || rsp_dat_s !== '0) begin
      fails++; $display("FAIL timeout_rsp: timeout=%b data=%h, required 1 0", rsp_to_s, rsp_dat_s);
    end
  endtask

  task automatic test_stray();
    int p0, r0;
    logic [DROPW-1:0] d0;
    p0 = pop_cnt; r0 = rsp_cnt; d0 = drop_cnt;
    issue(1'b1, 4'd6, 4'd1, 8'h07, '0);
    push_word(4'd6, 4'd1, 8'h11, CMD_WR, 64'hBAD);
    push_word(4'd6, 4'd1, RSP_REG, CMD_WR, 64'hCAFE_F00D);
    wait_rsp(r0);
    repeat (3) @(negedge clk);
    tests++;
    if (drop_cnt - d0 !== 1) begin
      fails++; $display("FAIL stray_drop: got %0d drops, required 1", drop_cnt - d0);
    end
    tests++;
    if (pop_cnt - p0 !== 2 || pop_cyc - prev_pop_cyc !== 2) begin
      fails++; $display("FAIL stray_pops: %0d pops spaced %0d, required 2 spaced 2", pop_cnt - p0, pop_cyc - prev_pop_cyc);
    end
    tests++;
    if (rsp_dat_s !== 64'hCAFE_F00D || rsp_to_s !== 1'b0) begin
      fails++; $display("FAIL stray_rsp: data=%h timeout=%b, required cafef00d 0", rsp_dat_s, rsp_to_s);
    end
  endtask

  task automatic test_reset_mid();
    int w0, r0, p0;
    w0 = wr_cnt; r0 = rsp_cnt;
    issue(1'b1, 4'd2, 4'd7, 8'h05, '0);
    for (int i = 0; i < 20 && wr_cnt == w0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset: busy=%b req_ready=%b rsp_valid=%b, required 0 1 0", busy, req_ready, rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (30) @(negedge clk);
    tests++;
    if (rsp_cnt !== r0 || wr_cnt !== w0) begin
      fails++; $display("FAIL mid_quiet: rsp_valid=%0d wr_en=%0d after reset, required 0 0", rsp_cnt - r0, wr_cnt - w0);
    end
    p0 = pop_cnt;
    push_word(4'd2, 4'd7, RSP_REG, CMD_WR, 64'h5555);
    repeat (6) @(negedge clk);
    tests++;
    if (drop_cnt !== 16'd1 || pop_cnt - p0 !== 1 || rsp_cnt !== r0) begin
      fails++; $display("FAIL mid_late: drop=%0d pops=%0d rsp=%0d, required 1 1 0", drop_cnt, pop_cnt - p0, rsp_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int w0, r0;
    w0 = wr_cnt; r0 = rsp_cnt;
    issue(1'b0, 4'd9, 4'd9, 8'h40, 64'h1);
    wait_rsp(r0);
    issue(1'b0, 4'd8, 4'd8, 8'h41, 64'h2);
    wait_rsp(r0 + 1);
    repeat (2) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 2 || rsp_cnt - r0 !== 2 || s_reg !== 8'h41 || s_data !== 64'h2) begin
      fails++; $display("FAIL b2b: pushes=%0d rsps=%0d reg=%h data=%h, required 2 2 41 2",
                        wr_cnt - w0, rsp_cnt - r0, s_reg, s_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_rfd_stall();
    test_read();
    test_timeout();
    test_stray();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
